// File: rtl/aes_bram_pkg.sv
// Shared types and constants for the AES-side BRAM responder and its address map.
package aes_bram_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdWait  = 2'd1,
    StWrIssue = 2'd2,
    StAck     = 2'd3
  } aes_bram_state_e;

  localparam int unsigned DataWidth = 32;
  localparam logic [3:0]  ByteEnAll = 4'hF;
  localparam int unsigned RdLatMin  = 1;
  localparam int unsigned RdLatMax  = 3;
  localparam int unsigned LatCntW   = 2;

endpackage

// File: rtl/aes_bram_addr_map.sv
// Combinational byte-to-word address translation with alignment and range check.
module aes_bram_addr_map #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]       byte_addr,
  output logic [ADDR_W-1:0] word_addr,
  output logic              addr_ok
);

  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [1:0]  unused_offset_lsb;

  assign offset            = byte_addr - BASE_ADDR;
  assign word_idx          = offset[31:2];
  assign unused_offset_lsb = offset[1:0];
  assign word_addr         = word_idx[ADDR_W-1:0];

  // Range is judged on the full index so out-of-range addresses cannot alias in.
  assign addr_ok = (byte_addr[1:0] == 2'b00) &&
                   (byte_addr >= BASE_ADDR) &&
                   ({2'b00, word_idx} < DEPTH);

endmodule

// File: rtl/aes_bram_responder.sv
// BRAM-side responder for the AES single-word four-phase read/write handshake.
// Optional address rejection is enabled with `define AES_BRAM_RANGE_CHECK_EN.
module aes_bram_responder
  import aes_bram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned RD_LAT    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 aes_clk,
  input  logic                 aes_rst_n,
  input  logic                 aes_start_read,
  input  logic                 aes_start_write,
  input  logic [31:0]          aes_bram_addr,
  input  logic [DataWidth-1:0] aes_bram_write_data,
  output logic [DataWidth-1:0] aes_bram_read_data,
  output logic                 bram_complete,
  output logic                 bram_err,
  output logic                 busy,
  output logic [ADDR_W-1:0]    bram_addr_o,
  output logic                 bram_en,
  output logic [3:0]           bram_we,
  output logic [DataWidth-1:0] bram_din,
  input  logic [DataWidth-1:0] bram_dout
);

  // Out-of-range latencies are clamped to the legal window.
  localparam int unsigned RdLatEff = (RD_LAT < RdLatMin) ? RdLatMin :
                                     (RD_LAT > RdLatMax) ? RdLatMax : RD_LAT;
  localparam logic [LatCntW-1:0] LatInit = LatCntW'(RdLatEff - 1);

  aes_bram_state_e    state_q;
  logic [LatCntW-1:0] lat_cnt_q;
  logic               err_pend_q;
  logic [ADDR_W-1:0]  word_addr;
  logic               addr_ok;
  logic               reject;

  aes_bram_addr_map #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_map (
    .byte_addr(aes_bram_addr),
    .word_addr(word_addr),
    .addr_ok  (addr_ok)
  );

`ifdef AES_BRAM_RANGE_CHECK_EN
  assign reject = ~addr_ok;
`else
  logic unused_addr_ok;
  assign unused_addr_ok = addr_ok;
  assign reject         = 1'b0;
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state_q            <= StIdle;
      lat_cnt_q          <= '0;
      err_pend_q         <= 1'b0;
      aes_bram_read_data <= '0;
      bram_complete      <= 1'b0;
      bram_err           <= 1'b0;
      bram_addr_o        <= '0;
      bram_en            <= 1'b0;
      bram_we            <= 4'h0;
      bram_din           <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aes_start_read || aes_start_write) begin
            bram_addr_o <= word_addr;
            err_pend_q  <= reject | (aes_start_read & aes_start_write);
            if (reject) begin
              // Rejected requests reuse the one-cycle issue state with no BRAM access.
              state_q <= StWrIssue;
            end else if (aes_start_read) begin
              bram_en   <= 1'b1;
              lat_cnt_q <= LatInit;
              state_q   <= StRdWait;
            end else begin
              bram_en  <= 1'b1;
              bram_we  <= ByteEnAll;
              bram_din <= aes_bram_write_data;
              state_q  <= StWrIssue;
            end
          end
        end
        StRdWait: begin
          bram_en <= 1'b0;
          if (lat_cnt_q == '0) begin
            aes_bram_read_data <= bram_dout;
            bram_complete      <= 1'b1;
            bram_err           <= err_pend_q;
            state_q            <= StAck;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StWrIssue: begin
          bram_en       <= 1'b0;
          bram_we       <= 4'h0;
          bram_complete <= 1'b1;
          bram_err      <= err_pend_q;
          state_q       <= StAck;
        end
        StAck: begin
          if (!aes_start_read && !aes_start_write) begin
            bram_complete <= 1'b0;
            bram_err      <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/aes_bram_responder.md
Name: aes_bram_responder

Overview:
- Responder (BRAM side) of the AES engine's single-word read/write handshake.
- Accepts aes_start_read / aes_start_write with a 32-bit byte address and drives one access on a 32-bit true-BRAM port.
- Returns read data and asserts bram_complete, using a four-phase handshake.
- Sits between the AES control FSM and the block-RAM port shared with the AXI-side chunk buffer.

Parameters:
- ADDR_W, 12, BRAM word-address width.
- DEPTH, 4096, number of valid 32-bit words (DEPTH <= 2^ADDR_W).
- RD_LAT, 2, BRAM read latency in cycles from bram_en to valid bram_dout (legal 1..3).
- BASE_ADDR, 32'h0000_0000, byte address mapped to BRAM word 0.

Ports:
- aes_clk  in  1  clock, all logic on rising edge.
- aes_rst_n  in  1  asynchronous active-low reset.
- aes_start_read  in  1  read request, held high until bram_complete is seen.
- aes_start_write  in  1  write request, held high until bram_complete is seen.
- aes_bram_addr  in  32  byte address of the access.
- aes_bram_write_data  in  32  write data, sampled at acceptance.
- aes_bram_read_data  out  32  registered read data.
- bram_complete  out  1  access done; held until the request is dropped.
- bram_err  out  1  access rejected; valid while bram_complete is high.
- busy  out  1  high in any state other than IDLE.
- bram_addr_o  out  ADDR_W  BRAM word address.
- bram_en  out  1  BRAM enable, one-cycle pulse per access.
- bram_we  out  4  byte write enables, 4'hF on write, else 0.
- bram_din  out  32  BRAM write data.
- bram_dout  in  32  BRAM read data.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and all outputs to 0, including aes_bram_read_data and the RD_LAT counter.
- Word address = (aes_bram_addr - BASE_ADDR) >> 2, truncated to ADDR_W bits; registered into bram_addr_o at acceptance.
- FSM states: IDLE, RD_WAIT, WR_ISSUE, ACK.
- IDLE, start sampled high at edge E0 (accept):
  - aes_start_read=1: register address; bram_en=1 for the cycle after E0; go to RD_WAIT.
  - aes_start_write=1 only: register address and data; bram_en=1 and bram_we=4'hF for the cycle after E0; go to WR_ISSUE.
  - Both high: service the read, ignore the write; bram_err=1 is reported with that completion.
- RD_WAIT: count RD_LAT cycles. At edge E0+RD_LAT, capture bram_dout into aes_bram_read_data, set bram_complete=1, go to ACK.
- WR_ISSUE: at edge E0+1, bram_en and bram_we return to 0, bram_complete=1, go to ACK.
- ACK:
  - Hold bram_complete and bram_err until both start inputs are sampled low.
  - On that edge, clear both outputs and return to IDLE.
  - The earliest new accept is the following edge.
  - Minimum request spacing is one low cycle of start; the responder must sustain this back-to-back.
- aes_bram_read_data holds its value until the next successful read completes. Writes and errors never change it.
- A start asserted while busy is ignored until IDLE; there is no queueing.
- Reset mid-access: the BRAM access is abandoned, and a write may or may not have landed. After reset, a still-asserted start is accepted as a new request.
- bram_en must never be high for more than one cycle per accepted request.

Optional Feature:
- Macro: AES_BRAM_RANGE_CHECK_EN.
- Defined: a request is rejected if any of the following holds: aes_bram_addr[1:0] != 0, aes_bram_addr < BASE_ADDR, or word index >= DEPTH.
  - Rejected request: no bram_en pulse; bram_complete=1 and bram_err=1 at E0+1 via ACK; read data unchanged.
- Not defined: no checks; the address wraps modulo 2^ADDR_W; bram_err is only set for simultaneous read+write.

Decomposition:
- Shared package aes_bram_pkg holds:
  - FSM state encoding (IDLE=0, RD_WAIT=1, WR_ISSUE=2, ACK=3);
  - BRAM data width 32;
  - byte-enable constant 4'hF;
  - RD_LAT legal range constants.
- One natural sub-module: aes_bram_addr_map, combinational byte-to-word translation plus range/alignment check, reused by the AXI-side port.

Test Plan:
- Reset, then single write: addr 32'h10, data 32'hDEADBEEF.
  - bram_en/bram_we=4'hF pulse for exactly one cycle with bram_addr_o=4.
  - bram_complete rises at E0+1 and stays high until start drops.
- Read addr 32'h10 with RD_LAT=2 (BRAM model returns 32'hDEADBEEF): bram_complete rises at E0+2 with aes_bram_read_data=32'hDEADBEEF, bram_err=0.
- Four back-to-back reads (addr 0x20,0x24,0x28,0x2C), start low one cycle between each: four completions in order, word addresses 8..11, no dropped request.
- Simultaneous read+write at addr 0x30: the read is serviced, bram_we stays 0, bram_err=1 with bram_complete.
- With AES_BRAM_RANGE_CHECK_EN, DEPTH=16:
  - Read at 32'h40 gives no bram_en, bram_complete+bram_err at E0+1, read data unchanged.
  - Read at 32'h12 (misaligned) gives the same response.
- Assert aes_rst_n low during RD_WAIT, then release with start held high: outputs are 0 during reset, a new access is accepted, and it completes normally.
